// File: rtl/fp_pkg.sv
// Shared constants and state encoding for the serial floating-point normaliser.
package fp_pkg;

    localparam int unsigned MAG_W = 11;
    localparam int unsigned EXP_W = 3;
    localparam int unsigned SIG_W = 4;

    localparam logic [EXP_W-1:0] EXP_MAX = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StNorm,
        StRound,
        StDone
    } state_t;

endpackage

// File: rtl/fp_round.sv
// Round-half-up of a normalised significand with carry renormalisation and saturation.
module fp_round #(
    parameter int unsigned EXP_W = fp_pkg::EXP_W,
    parameter int unsigned SIG_W = fp_pkg::SIG_W
) (
    input  logic [SIG_W-1:0] fp,
    input  logic             r,
    input  logic [EXP_W-1:0] e_in,
    output logic [SIG_W-1:0] f,
    output logic [EXP_W-1:0] e_out
);

    localparam logic [EXP_W-1:0] EMax = {EXP_W{1'b1}};

    logic [SIG_W:0] sum;

    always_comb begin
        sum   = {1'b0, fp} + {{SIG_W{1'b0}}, r};
        f     = sum[SIG_W-1:0];
        e_out = e_in;
        if (sum[SIG_W]) begin
            // Carry out of the significand: renormalise, or clamp at the top exponent.
            if (e_in == EMax) begin
                f = {SIG_W{1'b1}};
            end else begin
                f     = {1'b1, {(SIG_W-1){1'b0}}};
                e_out = e_in + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_normalizer.sv
// Serial normaliser: sign-magnitude in, (S, E, F) floating-point code out, valid/ready on both sides.
module fp_normalizer
    import fp_pkg::*;
#(
    parameter int unsigned MAG_W = fp_pkg::MAG_W,
    parameter int unsigned EXP_W = fp_pkg::EXP_W,
    parameter int unsigned SIG_W = fp_pkg::SIG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s_in,
    input  logic [MAG_W-1:0] x_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             s_out,
    output logic [EXP_W-1:0] e_out,
    output logic [SIG_W-1:0] f_out
);

    localparam logic [EXP_W-1:0] CntMax = {EXP_W{1'b1}};

    state_t           state_q, state_d;
    logic [MAG_W-1:0] mag_q, mag_d;
    logic [EXP_W-1:0] cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             s_q, s_d;
    logic [EXP_W-1:0] e_q, e_d;
    logic [SIG_W-1:0] f_q, f_d;
    logic [EXP_W-1:0] e_rnd;
    logic [SIG_W-1:0] f_rnd;

    fp_round #(
        .EXP_W (EXP_W),
        .SIG_W (SIG_W)
    ) u_round (
        .fp    (mag_q[MAG_W-1 -: SIG_W]),
        .r     (mag_q[MAG_W-1-SIG_W]),
        .e_in  (CntMax - cnt_q),
        .f     (f_rnd),
        .e_out (e_rnd)
    );

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        s_d     = s_q;
        e_d     = e_q;
        f_d     = f_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d  = s_in;
                    mag_d   = x_in;
                    cnt_d   = '0;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (mag_q[MAG_W-1] || cnt_q == CntMax) begin
                    state_d = StRound;
                end else begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRound: begin
                s_d     = sign_q;
                e_d     = e_rnd;
                f_d     = f_rnd;
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mag_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            s_q     <= 1'b0;
            e_q     <= '0;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            s_q     <= s_d;
            e_q     <= e_d;
            f_q     <= f_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign s_out     = s_q;
    assign e_out     = e_q;
    assign f_out     = f_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed and randomised checks of fp_normalizer against an arithmetic reference model.
module tb_fp_normalizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        s_in;
    logic [10:0] x_in;
    logic        out_valid;
    logic        out_ready;
    logic        s_out;
    logic [2:0]  e_out;
    logic [3:0]  f_out;

    int total = 0;
    int bad   = 0;

    fp_normalizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s_in      (s_in),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_out     (s_out),
        .e_out     (e_out),
        .f_out     (f_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // value = F * 2^E, F rounded half-up from the top four bits after normalisation
    function automatic void model(input int x, output int e, output int f, output int lat);
        int lz;
        int m;
        int sum;
        lz = 0;
        while (lz < 7 && (x << lz) < 1024) lz++;
        m   = x << lz;
        e   = 7 - lz;
        sum = (m + 64) / 128;
        if (sum == 16) begin
            if (e < 7) begin
                f = 8;
                e = e + 1;
            end else begin
                f = 15;
            end
        end else begin
            f = sum;
        end
        lat = lz + 2;
    endfunction

    // Accept one sample and wait for its result; leaves the DUT in DONE.
    task automatic send(input logic s, input int x, input string tag);
        int e_exp, f_exp, lat_exp, edges;
        model(x, e_exp, f_exp, lat_exp);
        @(negedge clk);
        in_valid = 1'b1;
        s_in     = s;
        x_in     = 11'(x);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        s_in     = 1'($urandom);
        x_in     = 11'($urandom);
        edges    = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, ".latency"}, 32'(edges), 32'(lat_exp));
        chk({tag, ".s"}, 32'(s_out), 32'(s));
        chk({tag, ".e"}, 32'(e_out), 32'(e_exp));
        chk({tag, ".f"}, 32'(f_out), 32'(f_exp));
    endtask

    task automatic retire(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".ov_drop"}, 32'(out_valid), 32'd0);
        chk({tag, ".ir_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [2:0] e_hold;
        logic [3:0] f_hold;
        int         xr;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        s_in      = 1'b0;
        x_in      = '0;
        #2;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.s", 32'(s_out), 32'd0);
        chk("rst.e", 32'(e_out), 32'd0);
        chk("rst.f", 32'(f_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send(1'b0, 1023, "x1023");
        retire("x1023");
        send(1'b1, 15, "x15");
        retire("x15");
        send(1'b0, 2047, "x2047");
        retire("x2047");
        send(1'b1, 0, "x0");
        retire("x0");
        send(1'b0, 45, "x45");
        retire("x45");

        // Stall in DONE while upstream keeps offering a sample.
        send(1'b1, 1023, "stall");
        e_hold = e_out;
        f_hold = f_out;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            s_in     = 1'b0;
            x_in     = 11'd100;
            @(posedge clk);
            #1;
            chk("stall.in_ready", 32'(in_ready), 32'd0);
            chk("stall.out_valid", 32'(out_valid), 32'd1);
            chk("stall.e", 32'(e_out), 32'(e_hold));
            chk("stall.f", 32'(f_out), 32'(f_hold));
            chk("stall.s", 32'(s_out), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("stall.retire_ov", 32'(out_valid), 32'd0);
        chk("stall.retire_ir", 32'(in_ready), 32'd1);
        send(1'b0, 100, "x100");
        retire("x100");

        // Reset in the third NORM cycle of a long normalisation.
        send(1'b1, 2047, "pre_rst");
        retire("pre_rst");
        @(negedge clk);
        in_valid = 1'b1;
        s_in     = 1'b1;
        x_in     = 11'd15;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        chk("midrst.s", 32'(s_out), 32'd0);
        chk("midrst.e", 32'(e_out), 32'd0);
        chk("midrst.f", 32'(f_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst.idle", 32'(in_ready), 32'd1);
        send(1'b0, 1023, "post_rst");
        retire("post_rst");

        for (int i = 0; i < 40; i++) begin
            xr = int'($urandom_range(0, 2047) >> $urandom_range(0, 11));
            send(1'($urandom), xr, $sformatf("rnd%0d_x%0d", i, xr));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            retire($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
